// File: rtl/bptt_seq_if.sv
// Handshake bundle between the LSTM history shift register, the BPTT sequence reader and the BPTT stage.
// Carries len_i only when BPTT_SEQ_LEN_EN is defined.
interface bptt_seq_if #(
  parameter int NUM_ITERATIONS = 68,
  parameter int WIDTH          = 32
) ();
  localparam int IDXW = (NUM_ITERATIONS > 1) ? $clog2(NUM_ITERATIONS) : 1;

  logic                             start;
  logic [NUM_ITERATIONS*WIDTH-1:0]  hist_i;
  logic signed [WIDTH-1:0]          data_o;
  logic [IDXW-1:0]                  idx_o;
  logic                             valid_o;
  logic                             ready_i;
  logic                             last_o;
  logic                             busy_o;
  logic                             done_o;
`ifdef BPTT_SEQ_LEN_EN
  logic [IDXW:0]                    len_i;
`endif

  modport master (
    output start, hist_i, ready_i,
`ifdef BPTT_SEQ_LEN_EN
    output len_i,
`endif
    input  data_o, idx_o, valid_o, last_o, busy_o, done_o
  );

  modport slave (
    input  start, hist_i, ready_i,
`ifdef BPTT_SEQ_LEN_EN
    input  len_i,
`endif
    output data_o, idx_o, valid_o, last_o, busy_o, done_o
  );
endinterface

// File: rtl/bptt_seq_reader.sv
// Snapshots the per-timestep history bus on start and streams it newest-first over valid/ready.
// Optional BPTT_SEQ_LEN_EN adds len_i to stream only the oldest min(len_i, NUM_ITERATIONS) words.
module bptt_seq_reader #(
  parameter int NUM_ITERATIONS = 68,
  parameter int WIDTH          = 32
) (
  input logic       clk,
  input logic       rst,
  bptt_seq_if.slave bus
);
  localparam int IDXW = (NUM_ITERATIONS > 1) ? $clog2(NUM_ITERATIONS) : 1;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [IDXW:0] LEN_MAX = (IDXW+1)'(NUM_ITERATIONS);

  logic [1:0]                             state_p0;
  logic [IDXW-1:0]                        cnt_p0;
  logic [NUM_ITERATIONS-1:0][WIDTH-1:0]   snap_p0;
  logic [IDXW:0]                          len_eff;
  logic                                   vld_p0;
  logic                                   xfer;

  always_comb begin
`ifdef BPTT_SEQ_LEN_EN
    len_eff = (bus.len_i > LEN_MAX) ? LEN_MAX : bus.len_i;
`else
    len_eff = LEN_MAX;
`endif
  end

  assign vld_p0 = (state_p0 == STREAM);
  assign xfer   = vld_p0 && bus.ready_i;

  // Stage p0: snapshot capture and countdown from the newest word to index 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      snap_p0  <= '0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (bus.start) begin
            snap_p0 <= bus.hist_i;
            if (len_eff == '0) begin
              state_p0 <= DONE;
            end else begin
              cnt_p0   <= IDXW'(len_eff - 1'b1);
              state_p0 <= STREAM;
            end
          end
        end
        STREAM: begin
          if (xfer) begin
            if (cnt_p0 == '0) state_p0 <= DONE;
            else              cnt_p0   <= cnt_p0 - 1'b1;
          end
        end
        DONE:    state_p0 <= IDLE;
        default: state_p0 <= IDLE;
      endcase
    end
  end

  // Data is forced to zero outside STREAM so a stale snapshot never leaks onto the bus
  assign bus.data_o  = vld_p0 ? signed'(snap_p0[cnt_p0]) : '0;
  assign bus.idx_o   = cnt_p0;
  assign bus.valid_o = vld_p0;
  assign bus.last_o  = vld_p0 && (cnt_p0 == '0);
  assign bus.busy_o  = (state_p0 != IDLE);
  assign bus.done_o  = (state_p0 == DONE);
endmodule

// File: tb/tb_bptt_seq_reader.sv
// Directed bench for bptt_seq_reader (NUM_ITERATIONS=4, WIDTH=8) with a queue scoreboard of expected beats.
module tb_bptt_seq_reader;
  localparam int N = 4;
  localparam int W = 8;
  localparam int MODE_NORM = 0;
  localparam int MODE_BP   = 1;
  localparam int MODE_ISO  = 2;
  localparam int MODE_BUSY = 3;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   idx;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bptt_seq_if #(.NUM_ITERATIONS(N), .WIDTH(W)) bus ();

  bptt_seq_reader #(.NUM_ITERATIONS(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t        q[$];
  int           checks = 0;
  int           errors = 0;
  int           beats = 0;
  int           done_cnt = 0;
  logic         stalled = 1'b0;
  logic [W-1:0] held_data;
  logic [1:0]   held_idx;
  logic         held_last;
  logic [N*W-1:0] ref_hist = 32'h44_33_22_11;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_words(input int len);
    beat_t b;
    for (int k = len - 1; k >= 0; k--) begin
      b.data = W'(ref_hist >> (k * W));
      b.idx  = 2'(k);
      b.last = (k == 0);
      q.push_back(b);
    end
  endtask

  // Called right after a falling edge: scoreboard pop on transfer, stability check while stalled
  task automatic mon();
    beat_t e;
    if (stalled) begin
      chk("stall_data", {24'b0, $unsigned(bus.data_o)}, {24'b0, held_data});
      chk("stall_idx",  {30'b0, bus.idx_o}, {30'b0, held_idx});
      chk("stall_last", {31'b0, bus.last_o}, {31'b0, held_last});
    end
    if (bus.valid_o && bus.ready_i) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("beat_data", {24'b0, $unsigned(bus.data_o)}, {24'b0, e.data});
        chk("beat_idx",  {30'b0, bus.idx_o}, {30'b0, e.idx});
        chk("beat_last", {31'b0, bus.last_o}, {31'b0, e.last});
        chk("beat_busy", {31'b0, bus.busy_o}, 32'd1);
      end
      beats++;
    end
    if (bus.done_o) done_cnt++;
    stalled   = bus.valid_o && !bus.ready_i && !rst;
    held_data = $unsigned(bus.data_o);
    held_idx  = bus.idx_o;
    held_last = bus.last_o;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'b0, bus.valid_o}, 32'd0);
    chk({tag, "_last"},  {31'b0, bus.last_o},  32'd0);
    chk({tag, "_busy"},  {31'b0, bus.busy_o},  32'd0);
    chk({tag, "_done"},  {31'b0, bus.done_o},  32'd0);
    chk({tag, "_data"},  {24'b0, $unsigned(bus.data_o)}, 32'd0);
  endtask

  // Entered with start already high in an IDLE cycle; returns at the falling edge of the next IDLE cycle
  task automatic run(input string tag, input int mode, input int exp_lat);
    int   n;
    logic seen;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (mode == MODE_ISO) bus.hist_i = '1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 100) begin
      n++;
      @(negedge clk);
      mon();
      if (n == 1) begin
        chk({tag, "_first_valid"}, {31'b0, bus.valid_o}, (exp_lat > 1) ? 32'd1 : 32'd0);
        chk({tag, "_first_busy"},  {31'b0, bus.busy_o}, 32'd1);
      end
      if (bus.done_o) begin
        seen = 1'b1;
      end else begin
        @(posedge clk); #1;
        if (mode == MODE_BP)   bus.ready_i = (n % 3 == 0);
        if (mode == MODE_BUSY) bus.start = (n + 1 == 2) || (n + 1 == exp_lat);
      end
    end
    chk({tag, "_done_latency"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_lat));
    chk({tag, "_all_beats_seen"}, 32'(q.size()), 32'd0);
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.ready_i = 1'b1;
    @(negedge clk);
    mon();
    chk_idle({tag, "_after"});
  endtask

  initial begin
    int dc0;
    int b0;
    bus.start   = 1'b0;
    bus.ready_i = 1'b0;
    bus.hist_i  = ref_hist;
`ifdef BPTT_SEQ_LEN_EN
    bus.len_i   = 3'd4;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    chk("reset_idx", {30'b0, bus.idx_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    mon();

    // Full stream with ready held high
    bus.ready_i = 1'b1;
    push_words(N);
    bus.start = 1'b1;
    run("full", MODE_NORM, N + 1);

    // Backpressure with ready pattern 1,0,0 repeating
    push_words(N);
    bus.start = 1'b1;
    run("bp", MODE_BP, 11);

    // History bus overwritten right after the snapshot
    push_words(N);
    bus.start = 1'b1;
    run("iso", MODE_ISO, N + 1);
    bus.hist_i = ref_hist;

    // Start pulses during STREAM and DONE are ignored; start in the following IDLE cycle is taken
    push_words(N);
    bus.start = 1'b1;
    run("busy", MODE_BUSY, N + 1);
    push_words(N);
    bus.start = 1'b1;
    run("b2b", MODE_NORM, N + 1);

    // Reset after two beats abandons the stream without a done pulse
    push_words(N);
    dc0 = done_cnt;
    b0  = beats;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 10 && beats < b0 + 2; i++) begin
      @(negedge clk);
      mon();
      if (beats < b0 + 2) begin
        @(posedge clk); #1;
      end
    end
    chk("rst_two_beats", 32'(beats - b0), 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.ready_i = 1'b0;
    @(negedge clk);
    mon();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    mon();
    chk_idle("midrst");
    chk("midrst_idx", {30'b0, bus.idx_o}, 32'd0);
    q.delete();
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      mon();
    end
    chk("midrst_no_done", 32'(done_cnt - dc0), 32'd0);
    bus.ready_i = 1'b1;
    push_words(N);
    bus.start = 1'b1;
    run("replay", MODE_NORM, N + 1);

`ifdef BPTT_SEQ_LEN_EN
    bus.len_i = 3'd2;
    push_words(2);
    bus.start = 1'b1;
    run("len2", MODE_NORM, 3);

    bus.len_i = 3'd0;
    b0 = beats;
    bus.start = 1'b1;
    run("len0", MODE_NORM, 1);
    chk("len0_no_beats", 32'(beats - b0), 32'd0);

    bus.len_i = 3'd7;
    push_words(N);
    bus.start = 1'b1;
    run("len7", MODE_NORM, N + 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
